seq_subtractor: RTL and testbench

- Multi-cycle subtractor computing A - B - Bin one SLICE-bit slice per cycle, LSB slice first.
- Borrow is carried between cycles.
- Valid/ready handshakes on both ends; result comes with borrow-out and Z/N/V flags.
- Serves as the ALU's area-lean subtract/compare path, alongside the single-cycle adder datapath.

---
 rtl/seq_subtractor.sv | 167 ++++++++++++++++
 tb/tb_seq_subtractor.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_subtractor.sv
// -----------------------------------------------------------------------------
// seq_subtractor
//
// Multi-cycle subtractor: diff = a - b - bin (modulo 2^WIDTH), processed one
// SLICE-bit slice per clock, least-significant slice first, with the borrow
// carried from one cycle to the next. This is the ALU's area-lean
// subtract/compare path; it reuses one SLICE-bit adder for every slice.
//
// Handshake: operation accepted on in_valid && in_ready (in_ready only in
// IDLE). Result presented with out_valid (only in DONE) and retired on
// out_valid && out_ready. Throughput is one operation per NSL+2 cycles.
//
// Parameters
//   WIDTH     operand / result width in bits
//   SLICE     bits processed per cycle; WIDTH must be a multiple of SLICE
//
// Ports
//   clk       clock, all state updates on rising edge
//   rst       synchronous active-high reset
//   in_valid  operands and bin valid
//   in_ready  block can accept an operation (IDLE)
//   a         minuend
//   b         subtrahend
//   bin       borrow-in
//   out_valid result valid (DONE)
//   out_ready consumer accepts result
//   diff      a - b - bin, modulo 2^WIDTH
//   bout      final borrow; 1 iff unsigned a < b + bin
//   zero      diff == 0
//   neg       diff[WIDTH-1]
//   ovf       signed overflow of the subtraction
// -----------------------------------------------------------------------------
module seq_subtractor #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int NSL   = WIDTH / SLICE;
  localparam int CNT_W = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSL - 1);

  generate
    if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
      $error("seq_subtractor: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Latched operands are kept as right-shifting registers, so the slice being
  // processed is always in the low SLICE bits and no variable part-select is
  // needed. After NSL-1 shifts the low slice holds the original top slice,
  // which is where the sign bits for the overflow flag are taken from.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             brw;

  logic [SLICE:0]   sl_res;
  logic [WIDTH-1:0] diff_nxt;
  logic             msb_a;
  logic             msb_b;
  logic             last;

  // One slice of a - b - bi computed as a + ~b + ~bi; the borrow out is the
  // inverted carry out. Returns {borrow, slice difference}.
  function automatic logic [SLICE:0] sub_slice(
    input logic [SLICE-1:0] x,
    input logic [SLICE-1:0] y,
    input logic             bi
  );
    logic [SLICE:0] s;
    s = {1'b0, x} + {1'b0, ~y} + {{SLICE{1'b0}}, ~bi};
    return {~s[SLICE], s[SLICE-1:0]};
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign last      = (cnt == LAST);

  always_comb begin
    sl_res   = sub_slice(a_sh[SLICE-1:0], b_sh[SLICE-1:0], brw);
    // New slice enters at the top; after NSL slices every slice sits at its
    // own position, so no clearing of diff is needed between operations.
    diff_nxt = WIDTH'({sl_res[SLICE-1:0], diff} >> SLICE);
    msb_a    = a_sh[SLICE-1];
    msb_b    = b_sh[SLICE-1];
  end

  // Control, result and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      zero  <= 1'b0;
      neg   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          diff <= diff_nxt;
          cnt  <= cnt + 1'b1;
          if (last) begin
            cnt   <= '0;
            bout  <= sl_res[SLICE];
            zero  <= (diff_nxt == '0);
            neg   <= diff_nxt[WIDTH-1];
            ovf   <= (msb_a != msb_b) && (diff_nxt[WIDTH-1] != msb_a);
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Operand / borrow datapath: no reset; contents only matter during RUN,
  // which always starts from a fresh latch in IDLE.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_sh <= a;
      b_sh <= b;
      brw  <= bin;
    end else if (state == RUN) begin
      a_sh <= a_sh >> SLICE;
      b_sh <= b_sh >> SLICE;
      brw  <= sl_res[SLICE];
    end
  end

endmodule

// File: tb/tb_seq_subtractor.sv
module tb_seq_subtractor;

  localparam int WIDTH = 32;
  localparam int SLICE = 8;
  localparam int NSL   = WIDTH / SLICE;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             neg;
  logic             ovf;

  seq_subtractor #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             z;
    logic             n;
    logic             v;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk;
  int   n_pass;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_chk++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, expv);
  endtask

  // Reference: full-width subtraction with an extra bit to catch the borrow.
  function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic bi);
    exp_t m;
    logic [WIDTH:0] f;
    f    = {1'b0, av} - {1'b0, bv} - {{WIDTH{1'b0}}, bi};
    m.d  = f[WIDTH-1:0];
    m.bo = f[WIDTH];
    m.z  = (f[WIDTH-1:0] == '0);
    m.n  = f[WIDTH-1];
    m.v  = (av[WIDTH-1] != bv[WIDTH-1]) && (f[WIDTH-1] != av[WIDTH-1]);
    return m;
  endfunction

  // Result monitor: handshake happens at the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("diff", diff, mon_e.d);
        chk("bout", bout, mon_e.bo);
        chk("zero", zero, mon_e.z);
        chk("neg",  neg,  mon_e.n);
        chk("ovf",  ovf,  mon_e.v);
      end
    end
  end

  // Called at posedge+1. Waits for in_ready, issues one op, checks latency,
  // and (if out_ready is high) checks the return to IDLE.
  task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic bi);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    a = av; b = bv; bin = bi; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back(model(av, bv, bi));
    // Scramble inputs: the latched operands must be unaffected.
    a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", n, NSL);
    if (out_ready) begin
      @(posedge clk); #1;
      chk("idle_after", {in_ready, out_valid}, 2'b10);
    end
  endtask

  logic [WIDTH-1:0] d0;
  logic [3:0]       f0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_in_ready",  in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff",      diff, 0);
    chk("rst_flags",     {bout, zero, neg, ovf}, 0);

    do_op(32'h00000005, 32'h00000003, 1'b0);
    do_op(32'h00000000, 32'h00000001, 1'b0);
    do_op(32'h80000000, 32'h00000001, 1'b0);
    do_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0);
    do_op(32'h12345678, 32'h12345677, 1'b1);
    do_op(32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1);
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    do_op(32'h00000000, 32'hFFFFFFFF, 1'b1);

    for (int i = 0; i < 8; i++) begin
      logic [WIDTH-1:0] ra;
      ra = $urandom;
      if (i % 4 == 3) do_op(ra, ra, 1'($urandom_range(0, 1)));
      else            do_op(ra, $urandom, 1'($urandom_range(0, 1)));
    end

    // Backpressure in DONE.
    out_ready = 1'b0;
    do_op(32'hDEADBEEF, 32'h0BADF00D, 1'b1);
    d0 = diff;
    f0 = {bout, zero, neg, ovf};
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a = $urandom; b = $urandom;
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready",  in_ready, 0);
      chk("bp_diff",      diff, d0);
      chk("bp_flags",     {bout, zero, neg, ovf}, f0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle", {in_ready, out_valid}, 2'b10);
    do_op(32'h00001000, 32'h00000FFF, 1'b0);

    // Reset after two RUN slices.
    a = 32'h00000000; b = 32'h00000001; bin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("abort_accepted", in_ready, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready",  in_ready, 1);
    chk("abort_diff",      diff, 0);
    chk("abort_flags",     {bout, zero, neg, ovf}, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_result", out_valid, 0);
    do_op(32'h00000010, 32'h00000001, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
